// File: rtl/mem_wb_skid_reg_if.sv
// MEM/WB handshake bundle: MEM-side entry channel plus WB-side head channel.
// slave = the skid register itself, master = the surrounding pipeline.
interface mem_wb_skid_reg_if #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RADDR_W = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [XLEN-1:0]    in_alu_result;
    logic [XLEN-1:0]    in_mem_data;
    logic [XLEN-1:0]    in_pc_plus4;
    logic [RADDR_W-1:0] in_rd;
    logic               in_reg_write;
    logic [1:0]         in_wb_sel;
    logic               out_ready;
    logic               out_valid;
    logic [RADDR_W-1:0] out_rd;
    logic [XLEN-1:0]    out_wb_data;
    logic               out_reg_write;

    modport slave (
        input  in_valid, in_alu_result, in_mem_data, in_pc_plus4,
               in_rd, in_reg_write, in_wb_sel, out_ready,
        output in_ready, out_valid, out_rd, out_wb_data, out_reg_write
    );

    modport master (
        output in_valid, in_alu_result, in_mem_data, in_pc_plus4,
               in_rd, in_reg_write, in_wb_sel, out_ready,
        input  in_ready, out_valid, out_rd, out_wb_data, out_reg_write
    );
endinterface

// File: rtl/mem_wb_skid_reg.sv
// MEM/WB pipeline register with 2-entry skid buffer, flush, writeback mux and x0 suppression.
// Optional retire counter enabled by defining MEM_WB_RETIRE_CNT_EN.
module mem_wb_skid_reg #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RADDR_W = 5,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    mem_wb_skid_reg_if.slave bus
`ifdef MEM_WB_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0] retire_cnt
`endif
);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_HEAD  = 2'd1,
        OCC_BOTH  = 2'd2
    } occ_e;

    occ_e               state;
    occ_e               state_nxt;

    logic [RADDR_W-1:0] h_rd;
    logic [XLEN-1:0]    h_data;
    logic               h_we;
    logic [RADDR_W-1:0] s_rd;
    logic [XLEN-1:0]    s_data;
    logic               s_we;

    logic               h_valid;
    logic               s_valid;
    logic               accept;
    logic               consume;
    logic               load_h;
    logic               load_s;
    logic               shift_s;
    logic [XLEN-1:0]    new_data;
    logic               new_we;

    assign h_valid = (state != OCC_EMPTY);
    assign s_valid = (state == OCC_BOTH);

    assign bus.in_ready = rst_n & ~s_valid & ~flush;
    assign accept       = bus.in_valid & bus.in_ready;
    assign consume      = h_valid & bus.out_ready;

    // Source is resolved at capture time so the output side carries no mux.
    always_comb begin
        new_data = bus.in_alu_result;
        case (bus.in_wb_sel)
            2'b01:   new_data = bus.in_mem_data;
            2'b10:   new_data = bus.in_pc_plus4;
            default: new_data = bus.in_alu_result;
        endcase
    end

    assign new_we = bus.in_reg_write & (bus.in_rd != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= OCC_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load_h    = 1'b0;
        load_s    = 1'b0;
        shift_s   = 1'b0;
        if (flush) begin
            state_nxt = OCC_EMPTY;
        end else begin
            case (state)
                OCC_EMPTY: begin
                    load_h = accept;
                    if (accept) state_nxt = OCC_HEAD;
                end
                OCC_HEAD: begin
                    if (consume) begin
                        load_h = accept;
                        if (!accept) state_nxt = OCC_EMPTY;
                    end else begin
                        load_s = accept;
                        if (accept) state_nxt = OCC_BOTH;
                    end
                end
                OCC_BOTH: begin
                    shift_s = consume;
                    if (consume) state_nxt = OCC_HEAD;
                end
                default: state_nxt = OCC_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_rd   <= '0;
            h_data <= '0;
            h_we   <= 1'b0;
            s_rd   <= '0;
            s_data <= '0;
            s_we   <= 1'b0;
        end else begin
            if (shift_s) begin
                h_rd   <= s_rd;
                h_data <= s_data;
                h_we   <= s_we;
            end else if (load_h) begin
                h_rd   <= bus.in_rd;
                h_data <= new_data;
                h_we   <= new_we;
            end
            if (load_s) begin
                s_rd   <= bus.in_rd;
                s_data <= new_data;
                s_we   <= new_we;
            end
        end
    end

    assign bus.out_valid     = h_valid;
    assign bus.out_rd        = h_rd;
    assign bus.out_wb_data   = h_data;
    assign bus.out_reg_write = h_valid & h_we;

`ifdef MEM_WB_RETIRE_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retire_cnt <= '0;
        end else if (consume && !flush) begin
            retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Randomised self-checking bench for mem_wb_skid_reg against a queue-based model.
// Retire counter checks compile in when MEM_WB_RETIRE_CNT_EN is defined.
module tb_mem_wb_skid_reg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned RADDR_W = 5;
    localparam int unsigned CNT_W   = 4;

    logic clk;
    logic rst_n;
    logic flush;

    mem_wb_skid_reg_if #(.XLEN(XLEN), .RADDR_W(RADDR_W)) bus ();

`ifdef MEM_WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] retire_cnt;
`endif

    mem_wb_skid_reg #(.XLEN(XLEN), .RADDR_W(RADDR_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .bus        (bus)
`ifdef MEM_WB_RETIRE_CNT_EN
        ,
        .retire_cnt (retire_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [RADDR_W-1:0] rd;
        logic [XLEN-1:0]    data;
        logic               we;
    } ent_t;

    // Model: FIFO of held entries (oldest first), capacity two.
    ent_t        mq[$];
    ent_t        last_h;
    int unsigned m_cnt;
    int          n_checks;
    int          n_fail;

    function automatic ent_t mk_entry();
        ent_t e;
        e.rd = bus.in_rd;
        e.we = bus.in_reg_write && (bus.in_rd != 0);
        case (bus.in_wb_sel)
            2'd1:    e.data = bus.in_mem_data;
            2'd2:    e.data = bus.in_pc_plus4;
            default: e.data = bus.in_alu_result;
        endcase
        return e;
    endfunction

    function automatic logic exp_ready();
        return rst_n && !flush && (mq.size() < 2);
    endfunction

    function automatic ent_t exp_head();
        return (mq.size() > 0) ? mq[0] : last_h;
    endfunction

    task automatic cycle();
        bit   acc;
        bit   cons;
        ent_t e;
        acc  = rst_n && !flush && (mq.size() < 2) && bus.in_valid;
        cons = (mq.size() > 0) && bus.out_ready;
        e    = mk_entry();
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            last_h = '0;
            m_cnt  = 0;
        end else if (flush) begin
            mq.delete();
        end else begin
            if (cons) begin
                void'(mq.pop_front());
                m_cnt++;
            end
            if (acc) mq.push_back(e);
        end
        if (mq.size() > 0) last_h = mq[0];
        #2;
    endtask

    task automatic drive(input logic v, input logic [XLEN-1:0] alu, input logic [XLEN-1:0] mem,
                         input logic [XLEN-1:0] pc, input logic [RADDR_W-1:0] rd,
                         input logic we, input logic [1:0] sel);
        bus.in_valid      = v;
        bus.in_alu_result = alu;
        bus.in_mem_data   = mem;
        bus.in_pc_plus4   = pc;
        bus.in_rd         = rd;
        bus.in_reg_write  = we;
        bus.in_wb_sel     = sel;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, '0, '0, '0, '0, 1'b0, 2'd0);
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (bus.in_ready !== 1'b0) begin
                n_fail++; $display("FAIL reset_in_ready: got %b exp 0", bus.in_ready);
            end
            cycle();
        end
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b exp 0", bus.out_valid);
        end
        n_checks++;
        if (bus.out_wb_data !== 32'h0 || bus.out_rd !== 5'd0 || bus.out_reg_write !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs: got data=%h rd=%0d we=%b exp 0/0/0",
                               bus.out_wb_data, bus.out_rd, bus.out_reg_write);
        end
`ifdef MEM_WB_RETIRE_CNT_EN
        n_checks++;
        if (retire_cnt !== 4'd0) begin
            n_fail++; $display("FAIL reset_retire_cnt: got %0d exp 0", retire_cnt);
        end
`endif
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_ready: got %b exp 1", bus.in_ready);
        end
    endtask

    task automatic test_passthrough();
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h0000_1234, 32'h0, 32'h0, 5'd5, 1'b1, 2'b00);
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL pass_in_ready: got %b exp 1", bus.in_ready);
        end
        cycle();
        bus.in_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_wb_data !== 32'h0000_1234 ||
            bus.out_rd !== 5'd5 || bus.out_reg_write !== 1'b1 || bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL pass_head: got v=%b data=%h rd=%0d we=%b rdy=%b exp 1/00001234/5/1/1",
                               bus.out_valid, bus.out_wb_data, bus.out_rd, bus.out_reg_write, bus.in_ready);
        end
        cycle();
    endtask

    task automatic test_wb_mux();
        logic [XLEN-1:0] exp_d [4];
        logic            exp_w [4];
        exp_d = '{32'hDEAD_BEEF, 32'h0000_0100, 32'h0000_0007, 32'h0000_0055};
        exp_w = '{1'b1, 1'b1, 1'b1, 1'b0};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       drive(1'b1, 32'h1, 32'hDEAD_BEEF, 32'h2, 5'd6, 1'b1, 2'b01);
                1:       drive(1'b1, 32'h3, 32'h4, 32'h0000_0100, 5'd1, 1'b1, 2'b10);
                2:       drive(1'b1, 32'h7, 32'h5, 32'h6, 5'd31, 1'b1, 2'b11);
                default: drive(1'b1, 32'h55, 32'h8, 32'h9, 5'd0, 1'b1, 2'b00);
            endcase
            cycle();
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_wb_data !== exp_d[i] || bus.out_reg_write !== exp_w[i]) begin
                n_fail++; $display("FAIL wb_mux[%0d]: got v=%b data=%h we=%b exp 1/%h/%b",
                                   i, bus.out_valid, bus.out_wb_data, bus.out_reg_write, exp_d[i], exp_w[i]);
            end
        end
        bus.in_valid = 1'b0;
        cycle();
    endtask

    task automatic test_skid_stall();
        logic [XLEN-1:0] got[$];
        bus.out_ready = 1'b0;
        drive(1'b1, 32'hA, 32'h0, 32'h0, 5'd1, 1'b1, 2'b00);
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL skid_ready_a: got %b exp 1", bus.in_ready);
        end
        cycle();
        drive(1'b1, 32'hB, 32'h0, 32'h0, 5'd2, 1'b1, 2'b00);
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL skid_ready_b: got %b exp 1", bus.in_ready);
        end
        cycle();
        drive(1'b1, 32'hC, 32'h0, 32'h0, 5'd3, 1'b1, 2'b00);
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (bus.in_ready !== 1'b0 || bus.out_wb_data !== 32'hA) begin
                n_fail++; $display("FAIL skid_full[%0d]: got rdy=%b data=%h exp 0/0000000a",
                                   i, bus.in_ready, bus.out_wb_data);
            end
            cycle();
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bit took_c;
            #1;
            n_checks++;
            if (bus.in_ready !== exp_ready() || bus.out_valid !== (mq.size() > 0)) begin
                n_fail++; $display("FAIL skid_drain[%0d]: got rdy=%b v=%b exp %b/%b",
                                   i, bus.in_ready, bus.out_valid, exp_ready(), mq.size() > 0);
            end
            if (bus.out_valid && bus.out_ready) got.push_back(bus.out_wb_data);
            took_c = bus.in_valid && bus.in_ready;
            cycle();
            if (took_c) bus.in_valid = 1'b0;
        end
        n_checks++;
        if (got.size() != 3 || got[0] !== 32'hA || got[1] !== 32'hB || got[2] !== 32'hC) begin
            n_fail++; $display("FAIL skid_order: got %0d entries %p exp A,B,C", got.size(), got);
        end
    endtask

    task automatic test_flush();
        int unsigned cnt_before;
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h11, 32'h0, 32'h0, 5'd4, 1'b1, 2'b00);
        cycle();
        drive(1'b1, 32'h22, 32'h0, 32'h0, 5'd5, 1'b1, 2'b00);
        cycle();
        cnt_before = m_cnt;
        drive(1'b1, 32'h33, 32'h0, 32'h0, 5'd6, 1'b1, 2'b00);
        bus.out_ready = 1'b1;
        flush = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL flush_in_ready: got %b exp 0", bus.in_ready);
        end
        cycle();
        flush = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_after: got v=%b rdy=%b exp 0/1", bus.out_valid, bus.in_ready);
        end
`ifdef MEM_WB_RETIRE_CNT_EN
        n_checks++;
        if (retire_cnt !== CNT_W'(cnt_before)) begin
            n_fail++; $display("FAIL flush_retire_cnt: got %0d exp %0d", retire_cnt, CNT_W'(cnt_before));
        end
`endif
        bus.in_valid = 1'b0;
        cycle();
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_not_captured: got v=%b exp 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h44, 32'h0, 32'h0, 5'd7, 1'b1, 2'b00);
        cycle();
        drive(1'b1, 32'h55, 32'h0, 32'h0, 5'd8, 1'b1, 2'b00);
        cycle();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_in_ready: got %b exp 0", bus.in_ready);
        end
        cycle();
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_wb_data !== 32'h0 || bus.out_rd !== 5'd0 ||
            bus.out_reg_write !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_outputs: got v=%b data=%h rd=%0d we=%b rdy=%b exp 0/0/0/0/0",
                               bus.out_valid, bus.out_wb_data, bus.out_rd, bus.out_reg_write, bus.in_ready);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_release: got %b exp 1", bus.in_ready);
        end
    endtask

`ifdef MEM_WB_RETIRE_CNT_EN
    task automatic test_retire_cnt();
        int unsigned budget;
        budget = 0;
        while (m_cnt < 17 && budget < 300) begin
            drive(1'b1, $urandom, $urandom, $urandom, 5'($urandom), 1'b1, 2'($urandom));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            cycle();
            budget++;
            n_checks++;
            if (retire_cnt !== CNT_W'(m_cnt)) begin
                n_fail++; $display("FAIL retire_track: got %0d exp %0d", retire_cnt, CNT_W'(m_cnt));
            end
        end
        n_checks++;
        if (m_cnt != 17) begin
            n_fail++; $display("FAIL retire_budget: got %0d consumes exp 17", m_cnt);
        end
        n_checks++;
        if (retire_cnt !== 4'd1) begin
            n_fail++; $display("FAIL retire_wrap: got %0d exp 1", retire_cnt);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        cycle();
        n_checks++;
        if (retire_cnt !== 4'd1) begin
            n_fail++; $display("FAIL retire_stall: got %0d exp 1", retire_cnt);
        end
    endtask
`endif

    task automatic test_random();
        ent_t h;
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom,
                  5'($urandom_range(0, 7)), 1'($urandom), 2'($urandom));
            bus.out_ready = ($urandom_range(0, 9) < 7);
            flush         = ($urandom_range(0, 15) == 0);
            #1;
            h = exp_head();
            n_checks++;
            if (bus.in_ready !== exp_ready() || bus.out_valid !== (mq.size() > 0)) begin
                n_fail++; $display("FAIL rand_hs[%0d]: got rdy=%b v=%b exp %b/%b",
                                   i, bus.in_ready, bus.out_valid, exp_ready(), mq.size() > 0);
            end
            n_checks++;
            if (bus.out_wb_data !== h.data || bus.out_rd !== h.rd ||
                bus.out_reg_write !== ((mq.size() > 0) && h.we)) begin
                n_fail++; $display("FAIL rand_head[%0d]: got data=%h rd=%0d we=%b exp %h/%0d/%b",
                                   i, bus.out_wb_data, bus.out_rd, bus.out_reg_write,
                                   h.data, h.rd, (mq.size() > 0) && h.we);
            end
`ifdef MEM_WB_RETIRE_CNT_EN
            n_checks++;
            if (retire_cnt !== CNT_W'(m_cnt)) begin
                n_fail++; $display("FAIL rand_cnt[%0d]: got %0d exp %0d", i, retire_cnt, CNT_W'(m_cnt));
            end
`endif
            cycle();
        end
        flush        = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_cnt    = 0;
        last_h   = '0;
        test_reset();
        test_passthrough();
        test_wb_mux();
        test_skid_stall();
        test_flush();
        test_reset_mid();
`ifdef MEM_WB_RETIRE_CNT_EN
        test_retire_cnt();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_wb_skid_reg.md
Name: mem_wb_skid_reg

Overview:
- Parametrised MEM/WB pipeline register, second generation. Sits between the MEM stage and the register-file write port.
- Adds to the plain register:
  - valid/ready handshake on both sides;
  - a 2-entry skid buffer, so a stalled WB port never drops data and full throughput is kept;
  - a synchronous flush;
  - an internal writeback-source mux (ALU, MEM or PC+4);
  - suppression of writes to x0.

Parameters:
- XLEN, 32, data width of the ALU result, memory data, PC+4 and writeback data.
- RADDR_W, 5, width of the destination register index.
- CNT_W, 32, width of the retire counter (used only with the optional feature).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset.
- in_valid  in  1  MEM stage presents an entry.
- in_ready  out  1  block can accept an entry this cycle.
- in_alu_result  in  XLEN  ALU result.
- in_mem_data  in  XLEN  load data.
- in_pc_plus4  in  XLEN  link address.
- in_rd  in  RADDR_W  destination register.
- in_reg_write  in  1  entry writes the register file.
- in_wb_sel  in  2  writeback source select: 00 ALU, 01 MEM, 10 PC+4, 11 reserved and treated as ALU.
- flush  in  1  discard all held entries.
- out_ready  in  1  WB port consumes the head entry this cycle.
- out_valid  out  1  head entry is valid.
- out_rd  out  RADDR_W  head destination register.
- out_wb_data  out  XLEN  head writeback data, already muxed.
- out_reg_write  out  1  qualified write enable.
- retire_cnt  out  CNT_W  entries consumed (present only with the optional feature).

Behaviour:
- Reset (already decided): one clock; reset is synchronous and active-low.
  - While rst_n=0 at a rising edge: both entries become invalid and all data registers clear to 0.
  - Resulting outputs: out_valid=0, out_rd=0, out_wb_data=0, out_reg_write=0, retire_cnt=0.
  - A reset asserted mid-operation discards all held entries with no partial output.
- in_ready:
  - in_ready = rst_n & ~skid_valid & ~flush.
  - It is a function of registered state plus flush only; it never depends combinationally on out_ready.
- Accept and consume:
  - Accept = in_valid & in_ready.
  - Consume = out_valid & out_ready.
- Writeback mux:
  - wb_data is selected from in_wb_sel at accept time and stored; there is no mux on the output side.
  - Stored enable = in_reg_write & (in_rd != 0).
- Storage:
  - Head register H (drives the outputs) and skid register S, each with its own valid bit. FIFO order: H is always the oldest entry.
- Next-state rules when flush=0:
  1. Consume with S valid: S moves to H. An accept in the same cycle cannot occur, because in_ready=0 while S is valid.
  2. Consume with S empty: an accepted entry loads H; with no accept, H becomes invalid.
  3. No consume with H valid: an accepted entry loads S, and in_ready drops on the next cycle.
  4. H empty: an accepted entry loads H. S is never valid while H is empty.
- Latency: 1 cycle from accept to out_valid when the block is empty. Sustained throughput is 1 entry per cycle while out_ready=1.
- Flush:
  - flush=1 at an edge invalidates H and S.
  - flush has priority over a simultaneous accept and consume: input is dropped (in_ready is already 0) and no consume is counted.
  - out_valid=0 in the following cycle.
- Output qualification:
  - out_reg_write = H_valid & H_we.
  - out_rd and out_wb_data hold the last H contents when H_valid=0, and must not be used in that case.
- Backpressure: while out_ready=0, H is stable and held (its contents do not change).
- Assertions for the bench:
  - S_valid implies H_valid.
  - Never accept while S_valid.

Optional Feature:
- Macro: MEM_WB_RETIRE_CNT_EN.
- Defined:
  - Port retire_cnt exists.
  - Increments by 1 on every consume where flush=0.
  - Wraps modulo 2^CNT_W.
  - Cleared by reset only; flush does not clear it.
- Undefined: the port and the counter logic are absent; all other behaviour is identical.

Test Plan:
1. Reset and passthrough.
   - Stimulus: rst_n=0 for 2 cycles, then accept {alu=0x0000_1234, rd=5, we=1, sel=00} with out_ready=1.
   - Required: next cycle out_valid=1, out_wb_data=0x1234, out_rd=5, out_reg_write=1; in_ready=1 throughout.
2. Source mux and x0 suppression.
   - Stimulus: sel=01 (mem=0xDEAD_BEEF), then sel=10 (pc+4=0x100), then sel=11 (alu=0x7), then rd=0 with we=1.
   - Required: data 0xDEADBEEF, 0x100, 0x7 in order; out_reg_write=0 for the rd=0 entry.
3. Skid under stall.
   - Stimulus: out_ready=0, in_valid=1 with entries A, B, C offered back to back.
   - Required: A and B accepted, in_ready=0 from the cycle after B is accepted, C held upstream; raise out_ready and see A, B, C on consecutive cycles with none lost or duplicated.
4. Flush priority.
   - Stimulus: H and S valid, assert flush together with in_valid=1 and out_ready=1.
   - Required: next cycle out_valid=0, in_ready=1; the offered entry is not captured; retire_cnt unchanged.
5. Reset mid-stall.
   - Stimulus: two entries held, drive rst_n=0 for one edge.
   - Required: out_valid=0, out_wb_data=0, out_rd=0, out_reg_write=0; in_ready=0 while rst_n=0, then in_ready=1.
6. Retire counter (with MEM_WB_RETIRE_CNT_EN, CNT_W=4).
   - Stimulus: 17 consumes.
   - Required: retire_cnt=1, showing wrap; no increment on cycles with out_ready=0.
